// File: rtl/sweep_pkg.sv
// Shared types and defaults for the up/down sweep sequencer.
// State encoding is fixed so it can be read directly off a debug bus.
package sweep_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_SWEEPS_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        UP   = 3'd2,
        DOWN = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/updown_count_core.sv
// Loadable up/down counter datapath.
// Load wins over enable; the count holds while disabled.
module updown_count_core
    import sweep_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             UpOrDown,
    output logic [WIDTH-1:0] Count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            Count <= '0;
        end else if (load) begin
            Count <= load_val;
        end else if (en) begin
            Count <= UpOrDown ? Count + ONE : Count - ONE;
        end
    end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Bounded up/down sweep sequencer driving the counter core.
// Turnarounds are loads so hi = all-ones and lo = 0 never wrap.
module updown_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int SWEEPS_W = DEF_SWEEPS_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                pause,
    input  logic [WIDTH-1:0]    lo,
    input  logic [WIDTH-1:0]    hi,
    input  logic [SWEEPS_W-1:0] sweeps,
    output logic [WIDTH-1:0]    Count,
    output logic                UpOrDown,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [SWEEPS_W-1:0] sweep_idx
);

    localparam logic [WIDTH-1:0]    ONE     = WIDTH'(1);
    localparam logic [SWEEPS_W-1:0] IDX_ONE = SWEEPS_W'(1);

    state_t              state, state_n;
    logic [WIDTH-1:0]    lo_q, hi_q;
    logic [SWEEPS_W-1:0] sweeps_q;
    logic [SWEEPS_W-1:0] idx_n;
    logic                dir_q, dir_n;
    logic                err_q, err_n;
    logic                latch;
    logic                core_en, core_load, core_dir;
    logic [WIDTH-1:0]    core_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lo_q      <= '0;
            hi_q      <= '0;
            sweeps_q  <= '0;
            sweep_idx <= '0;
            dir_q     <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            sweep_idx <= idx_n;
            dir_q     <= dir_n;
            err_q     <= err_n;
            if (latch) begin
                lo_q     <= lo;
                hi_q     <= hi;
                sweeps_q <= sweeps;
            end
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = sweep_idx;
        dir_n     = dir_q;
        err_n     = 1'b0;
        latch     = 1'b0;
        core_en   = 1'b0;
        core_load = 1'b0;
        core_dir  = dir_q;
        core_val  = lo_q;
        if (abort && state != IDLE) begin
            state_n = IDLE;
        end else if (pause && state inside {LOAD, UP, DOWN}) begin
            state_n = state;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        latch = 1'b1;
                        if (lo >= hi || sweeps == '0) begin
                            err_n = 1'b1;
                        end else begin
                            idx_n   = '0;
                            state_n = LOAD;
                        end
                    end
                end
                LOAD: begin
                    core_load = 1'b1;
                    core_val  = lo_q;
                    dir_n     = 1'b1;
                    state_n   = UP;
                end
                UP: begin
                    if (Count != hi_q) begin
                        core_en  = 1'b1;
                        core_dir = 1'b1;
                    end else begin
                        core_load = 1'b1;
                        core_val  = hi_q - ONE;
                        dir_n     = 1'b0;
                        state_n   = DOWN;
                    end
                end
                DOWN: begin
                    if (Count != lo_q) begin
                        core_en  = 1'b1;
                        core_dir = 1'b0;
                    end else begin
                        idx_n = sweep_idx + IDX_ONE;
                        if (idx_n == sweeps_q) begin
                            state_n = DONE;
                        end else begin
                            core_load = 1'b1;
                            core_val  = lo_q + ONE;
                            dir_n     = 1'b1;
                            state_n   = UP;
                        end
                    end
                end
                DONE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    updown_count_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .en       (core_en),
        .load     (core_load),
        .load_val (core_val),
        .UpOrDown (core_dir),
        .Count    (Count)
    );

    // A completion that coincides with abort or reset is swallowed.
    assign done     = (state == DONE) && !abort && !reset;
    assign busy     = (state != IDLE);
    assign err      = err_q;
    assign UpOrDown = dir_q;

endmodule

// File: doc/updown_sweep_ctrl.md
# updown_sweep_ctrl

Sequencer for the 16-bit up/down counter datapath. On a start handshake it loads a lower bound, counts up to an upper bound, reverses, and counts back down, repeating for a programmed number of sweeps. It owns the `UpOrDown` direction control and the count enable, supports pause and abort, and reports busy, done and error. It sits between the test or system control logic and the counter, replacing free-running direction toggling with bounded, cycle-exact sweeps.

## Interface
Parameters:
- `WIDTH`, 16: counter width.
- `SWEEPS_W`, 8: width of the sweep-count field.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high; highest priority.
- `start`  in  1  request; accepted only in IDLE.
- `abort`  in  1  cancel the active run.
- `pause`  in  1  freeze the count and state while high.
- `lo`  in  WIDTH  lower bound; sampled when start is accepted.
- `hi`  in  WIDTH  upper bound; sampled when start is accepted.
- `sweeps`  in  SWEEPS_W  number of up+down sweeps; sampled when start is accepted.
- `Count`  out  WIDTH  counter value.
- `UpOrDown`  out  1  1 = counting up, 0 = counting down.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at normal completion.
- `err`  out  1  one-cycle pulse when start is rejected.
- `sweep_idx`  out  SWEEPS_W  number of completed sweeps.

## Operation
- Reset values: `Count`=0, `UpOrDown`=1, `busy`=0, `done`=0, `err`=0, `sweep_idx`=0, state IDLE.
- Priority order: `reset` > `abort` > `pause` > normal operation.
- States: IDLE, LOAD, UP, DOWN, DONE.
- IDLE:
  - On `start`: latch `lo`, `hi`, `sweeps`.
  - If `lo >= hi` or `sweeps == 0`: pulse `err` for one cycle and stay in IDLE.
  - Otherwise: clear `sweep_idx` and go to LOAD.
- LOAD: `Count` <= `lo`, `UpOrDown` <= 1, go to UP.
- UP:
  - If `Count != hi`: `Count` + 1.
  - Else: `Count` <= `hi` - 1, `UpOrDown` <= 0, go to DOWN.
- DOWN:
  - If `Count != lo`: `Count` - 1.
  - Else: `sweep_idx` + 1.
    - If the new `sweep_idx` equals `sweeps`: go to DONE, `Count` holds.
    - Otherwise: `Count` <= `lo` + 1, `UpOrDown` <= 1, go to UP.
- DONE: `done` = 1 for this cycle only, then IDLE. `Count` holds `lo`.
- `pause` high in LOAD, UP or DOWN: `Count`, `UpOrDown`, `sweep_idx` and state are all held.
- `abort` in any non-IDLE state: go to IDLE on the next edge. `Count` and `UpOrDown` hold, no `done` pulse.
- `start` while `busy` is ignored; it is neither latched nor queued.
- No wrap-around: the turnaround happens at `hi` and `lo`, so `hi` = 2^WIDTH-1 and `lo` = 0 are legal with no overflow.
- Arithmetic: unsigned WIDTH-bit compares; `sweep_idx` is compared at SWEEPS_W width.

## Timing
- Start accepted at edge k: `Count` = `lo` after edge k+1.
- The count changes by exactly ±1 per unpaused cycle, except at a turnaround, which also takes one cycle (hi→hi-1, lo→lo+1).
- Latency from the start edge to the first `done` cycle: 2·(hi−lo)·sweeps + 2 edges, plus one per paused cycle.
- `busy` rises the cycle after start is accepted and falls in the cycle after `done`.
- `err` is asserted the cycle after the rejected start.
- Reset mid-run: all outputs take their reset values after the edge. No `done` or `err` is produced.

## Structure
- Shared package `sweep_pkg`:
  - state encoding constants (IDLE=0, LOAD=1, UP=2, DOWN=3, DONE=4, 3-bit);
  - default WIDTH and SWEEPS_W.
- Sub-module `updown_count_core`:
  - inputs: `clk`, `reset`, `en`, `load`, `load_val`, `UpOrDown`;
  - output: `Count`;
  - behaviour: load has priority over enable; holds when `en` = 0.
- The controller holds the FSM, the latched bounds and `sweep_idx`, and drives the core's `en`, `load` and direction.

## Test plan
- `lo`=2, `hi`=5, `sweeps`=2, start at edge k:
  - `Count` after edges k+1..k+13 = 2,3,4,5,4,3,2,3,4,5,4,3,2;
  - `sweep_idx` goes to 1 at k+8 and 2 at k+14;
  - `done`=1 only in the cycle after k+14; `busy`=0 after k+15.
- Rejected starts:
  - `lo`=5, `hi`=5 → `err` pulses once, `busy` stays 0;
  - `sweeps`=0 → same.
- `pause` held for 3 cycles while `Count`=4 going up:
  - `Count` stays 4 for those 3 cycles, then continues to 5;
  - `done` is delayed by exactly 3 cycles.
- `abort` when `Count`=3, DOWN: next cycle IDLE, `busy`=0, `Count`=3, no `done`.
- `reset` asserted mid-sweep:
  - all outputs take reset values (`Count`=0, `UpOrDown`=1);
  - a new `start` afterwards runs the normal sequence.
- `lo`=0xFFFD, `hi`=0xFFFF, `sweeps`=1:
  - `Count` sequence 0xFFFD,0xFFFE,0xFFFF,0xFFFE,0xFFFD with no wrap;
  - `start` pulsed mid-run is ignored.
